// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the pipeline and a single-port data memory.
// Holds each strobe for WAIT_CYCLES clocks, then presents a response until accepted.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned DATA_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              memread,
    output logic              memwrite,
    output logic [DATA_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_write_data,
    input  logic [DATA_W-1:0] memory_read_data
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                memread_q, memread_d;
    logic                memwrite_q, memwrite_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)      state_d = ACCESS;
            ACCESS:  if (wait_q == '0)   state_d = RESP;
            RESP:    if (rsp_ready)      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Strobes are registered alongside the state so they drop on the same edge that enters RESP.
    always_comb begin
        wait_d     = wait_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    wait_d     = CNT_W'(WAIT_CYCLES - 1);
                    memread_d  = !req_write;
                    memwrite_d = req_write;
                end
            end
            ACCESS: begin
                if (wait_q == '0) begin
                    memread_d  = 1'b0;
                    memwrite_d = 1'b0;
                    rdata_d    = memwrite_q ? '0 : memory_read_data;
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q     <= '0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            wait_q     <= wait_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        req_ready         = (state_q == IDLE);
        rsp_valid         = (state_q == RESP);
        busy              = (state_q != IDLE);
        memread           = memread_q;
        memwrite          = memwrite_q;
        memory_address    = addr_q;
        memory_write_data = wdata_q;
        rsp_rdata         = rdata_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (WAIT_CYCLES 1, 3, 4) each with its own data memory,
// checked against a transaction-level reference of memory contents and strobe timing.
module tb_mem_access_ctrl;

    logic       clk;
    logic       rst_n;
    logic       mem_clr;
    logic [2:0] req_valid;
    logic       req_write;
    logic [4:0] req_addr;
    logic [4:0] req_wdata;
    logic       rsp_ready;

    logic       req_ready [3];
    logic       rsp_valid [3];
    logic       busy      [3];
    logic       memread   [3];
    logic       memwrite  [3];
    logic [4:0] rsp_rdata [3];
    logic [4:0] maddr     [3];
    logic [4:0] mwdata    [3];
    logic [4:0] mrdata    [3];

    logic [4:0] mem_val [3][32];
    logic       mem_set [3][32];
    logic [4:0] ref_val [3][32];
    logic       ref_set [3][32];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [4:0] wdata;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [7];

    function automatic int wc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic [4:0] init_val(input int k, input logic [4:0] a);
        int v;
        if (k == 0 && a == 5'd11) return 5'd6;
        v = int'(a) * 13 + k * 7 + 9;
        return v[4:0];
    endfunction

    function automatic logic [4:0] ref_read(input int k, input logic [4:0] a);
        return ref_set[k][a] ? ref_val[k][a] : init_val(k, a);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_access_ctrl #(
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .DATA_W(5)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .req_valid        (req_valid[g]),
            .req_write        (req_write),
            .req_addr         (req_addr),
            .req_wdata        (req_wdata),
            .req_ready        (req_ready[g]),
            .rsp_valid        (rsp_valid[g]),
            .rsp_ready        (rsp_ready),
            .rsp_rdata        (rsp_rdata[g]),
            .busy             (busy[g]),
            .memread          (memread[g]),
            .memwrite         (memwrite[g]),
            .memory_address   (maddr[g]),
            .memory_write_data(mwdata[g]),
            .memory_read_data (mrdata[g])
        );
        assign mrdata[g] = mem_set[g][maddr[g]] ? mem_val[g][maddr[g]] : init_val(g, maddr[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 32; a++) begin
                if (mem_clr) mem_set[k][a] <= 1'b0;
            end
            if (!mem_clr && memwrite[k]) begin
                mem_val[k][maddr[k]] <= mwdata[k];
                mem_set[k][maddr[k]] <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic txn(input int k, input logic wr, input logic [4:0] a, input logic [4:0] d,
                       input logic [4:0] exp, input int bp, output int acc);
        int n;
        int st;
        req_write    = wr;
        req_addr     = a;
        req_wdata    = d;
        req_valid[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n == 50) check("req_ready_timeout", 0, 1);
        @(posedge clk); #1;
        acc = cyc;
        req_valid[k] = 1'b0;
        st = 0;
        n = 0;
        while (!rsp_valid[k] && n < 40) begin
            check("strobe_type", {memread[k], memwrite[k]}, wr ? 1 : 2);
            check("access_addr", maddr[k], a);
            if (wr) check("access_wdata", mwdata[k], d);
            check("access_req_ready", req_ready[k], 0);
            st++;
            @(posedge clk); #1; n++;
        end
        if (n == 40) check("rsp_valid_timeout", 0, 1);
        check("strobe_cycles", st, wc(k));
        check("rsp_latency", cyc - acc, wc(k));
        check("rsp_rdata", rsp_rdata[k], exp);
        check("resp_strobes", {memread[k], memwrite[k]}, 0);
        check("resp_busy", busy[k], 1);
        check("resp_req_ready", req_ready[k], 0);
        rsp_ready = (bp == 0);
        for (int i = 0; i < bp; i++) begin
            req_valid[k] = 1'b1;
            req_write    = !wr;
            req_addr     = ~a;
            req_wdata    = ~d;
            @(posedge clk); #1;
            check("bp_rsp_valid", rsp_valid[k], 1);
            check("bp_rdata_hold", rsp_rdata[k], exp);
            check("bp_req_ready", req_ready[k], 0);
            check("bp_strobes", {memread[k], memwrite[k]}, 0);
            if (i == bp - 1) rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready    = 1'b0;
        req_valid[k] = 1'b0;
        check("idle_req_ready", req_ready[k], 1);
        check("idle_rsp_valid", rsp_valid[k], 0);
        check("idle_busy", busy[k], 0);
        check("idle_strobes", {memread[k], memwrite[k]}, 0);
        check("idle_addr_hold", maddr[k], a);
        if (wr) begin
            ref_val[k][a] = d;
            ref_set[k][a] = 1'b1;
        end
    endtask

    initial begin
        int a1;
        int a2;
        int n;
        logic       wr;
        logic [4:0] ad;
        logic [4:0] dd;

        tbl[0] = '{1'b1, 5'd3,  5'd21, 5'd0};
        tbl[1] = '{1'b0, 5'd11, 5'd0,  5'd6};
        tbl[2] = '{1'b0, 5'd3,  5'd0,  5'd21};
        tbl[3] = '{1'b1, 5'd31, 5'd31, 5'd0};
        tbl[4] = '{1'b0, 5'd31, 5'd0,  5'd31};
        tbl[5] = '{1'b1, 5'd0,  5'd0,  5'd0};
        tbl[6] = '{1'b0, 5'd0,  5'd0,  5'd0};

        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 32; a++) begin
                ref_set[k][a] = 1'b0;
                ref_val[k][a] = 5'd0;
            end

        rst_n     = 1'b0;
        mem_clr   = 1'b1;
        req_valid = 3'b000;
        req_write = 1'b0;
        req_addr  = 5'd0;
        req_wdata = 5'd0;
        rsp_ready = 1'b0;
        #22;
        for (int k = 0; k < 3; k++) begin
            check("reset_req_ready", req_ready[k], 1);
            check("reset_busy", busy[k], 0);
            check("reset_rsp_valid", rsp_valid[k], 0);
            check("reset_strobes", {memread[k], memwrite[k]}, 0);
            check("reset_rdata", rsp_rdata[k], 0);
            check("reset_addr", maddr[k], 0);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        mem_clr = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            txn(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 0, a1);

        txn(0, 1'b1, 5'd7, 5'd9, 5'd0, 0, a1);
        txn(0, 1'b0, 5'd7, 5'd0, 5'd9, 0, a2);
        check("b2b_spacing_w1", a2 - a1, 3);
        txn(1, 1'b1, 5'd7, 5'd9, 5'd0, 0, a1);
        txn(1, 1'b0, 5'd7, 5'd0, 5'd9, 0, a2);
        check("b2b_spacing_w3", a2 - a1, 5);

        txn(1, 1'b0, 5'd11, 5'd0, ref_read(1, 5'd11), 0, a1);
        txn(0, 1'b0, 5'd11, 5'd0, 5'd6, 5, a1);

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 25; i++) begin
                wr = 1'($urandom_range(0, 1));
                ad = 5'($urandom_range(0, 31));
                dd = 5'($urandom_range(0, 31));
                txn(k, wr, ad, dd, wr ? 5'd0 : ref_read(k, ad), int'($urandom_range(0, 3)), a1);
            end

        // Abort a WAIT_CYCLES=4 load in its second strobe cycle.
        txn(2, 1'b1, 5'd20, 5'd17, 5'd0, 0, a1);
        txn(2, 1'b0, 5'd20, 5'd0, 5'd17, 0, a1);
        req_write    = 1'b0;
        req_addr     = 5'd5;
        req_wdata    = 5'd0;
        req_valid[2] = 1'b1;
        n = 0;
        while (!req_ready[2] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n == 50) check("abort_ready_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        check("abort_cycle1_memread", memread[2], 1);
        @(posedge clk); #1;
        check("abort_cycle2_memread", memread[2], 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_memread", memread[2], 0);
        check("abort_memwrite", memwrite[2], 0);
        check("abort_busy", busy[2], 0);
        check("abort_rsp_valid", rsp_valid[2], 0);
        check("abort_rdata", rsp_rdata[2], 0);
        check("abort_addr", maddr[2], 0);
        check("abort_wdata", mwdata[2], 0);
        check("abort_req_ready", req_ready[2], 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_abort_req_ready", req_ready[2], 1);
            check("post_abort_strobes", {memread[2], memwrite[2]}, 0);
        end
        txn(2, 1'b0, 5'd20, 5'd0, 5'd17, 2, a1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=%0d required=0", n_tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: number of clock cycles memread/memwrite stay asserted per access; legal range 1..15.
REQ-002 Parameter DATA_W, default 5: data and address width, matching the 5-bit data memory port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  pipeline requests a load/store.
REQ-006 req_write  input  1  1 = store, 0 = load; sampled with req_valid.
REQ-007 req_addr  input  DATA_W  access address.
REQ-008 req_wdata  input  DATA_W  store data.
REQ-009 req_ready  output  1  controller can accept a request.
REQ-010 rsp_valid  output  1  access complete; rsp_rdata valid for loads.
REQ-011 rsp_ready  input  1  pipeline accepts the response.
REQ-012 rsp_rdata  output  DATA_W  load data; 0 for stores.
REQ-013 busy  output  1  high in any state other than IDLE; pipeline stall.
REQ-014 memread  output  1  read strobe to data memory.
REQ-015 memwrite  output  1  write strobe to data memory.
REQ-016 memory_address  output  DATA_W  address to data memory.
REQ-017 memory_write_data  output  DATA_W  write data to data memory.
REQ-018 memory_read_data  input  DATA_W  combinational read data from data memory.

Function
REQ-019 FSM states IDLE, ACCESS, RESP shall be encoded in registers; all memory-side outputs shall be registered, not decoded from inputs.
REQ-020 IDLE: req_ready=1, memread=memwrite=0; on req_valid=1 at a rising edge, latch req_write/req_addr/req_wdata, load wait_cnt=WAIT_CYCLES-1, go ACCESS.
REQ-021 ACCESS: req_ready=0; memory_address/memory_write_data shall hold latched values for the whole state; exactly one of memread (load) or memwrite (store) shall be 1.
REQ-022 ACCESS: wait_cnt decrements each cycle; in the cycle wait_cnt==0, a load captures memory_read_data into rsp_rdata, a store sets rsp_rdata=0, and FSM goes RESP with strobes deasserted on that edge.
REQ-023 Strobe high time shall be exactly WAIT_CYCLES cycles per access; memory_address and memory_write_data shall not change while either strobe is 1.
REQ-024 RESP: rsp_valid=1, rsp_rdata stable, strobes 0, req_ready=0; on rsp_ready=1 go IDLE; otherwise hold indefinitely.
REQ-025 A new request shall not be accepted in the same cycle a response is consumed; minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
REQ-026 req_valid while not in IDLE shall be ignored; the requester holds req_valid until it sees req_ready=1.
REQ-027 busy = (state != IDLE).
REQ-028 memory_address and memory_write_data shall keep their last values in IDLE/RESP (no glitching to 0).

Reset
REQ-029 rst_n=0 shall immediately (asynchronously) force state=IDLE, memread=0, memwrite=0, rsp_valid=0, busy=0, rsp_rdata=0, memory_address=0, memory_write_data=0, wait_cnt=0.
REQ-030 Reset during ACCESS shall abort the access with no further strobe; after release, the controller shall be in IDLE with req_ready=1 on the first clock.

Verification
REQ-031 Store: WAIT_CYCLES=1, req addr=5'd3 wdata=5'd21 -> memwrite=1 one cycle with address 3 data 21; next cycle rsp_valid=1, rsp_rdata=0.
REQ-032 Load: memory model holds 5'd6 at address 11, req load addr=11 -> memread=1 one cycle; rsp_valid=1, rsp_rdata=6.
REQ-033 Latency: WAIT_CYCLES=3, load -> memread high exactly 3 cycles, address stable throughout, rsp_valid on 4th cycle after accept.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held, req_ready=0, new req_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-035 Reset mid-access: WAIT_CYCLES=4, assert rst_n=0 in 2nd ACCESS cycle -> memread drops without waiting for clk, all outputs 0, req_ready=1 after release.
REQ-036 Back-to-back: store 5'd9 to 7 then load 7 -> rsp_rdata=9; spacing between accepts equals WAIT_CYCLES+2.
